// File: rtl/rc4_decrypt_core.sv
// RC4 keystream (PRGA) + XOR stage: swaps through S RAM, decrypts the message ROM into the dec RAM.
// Build option: define CHECK_CHARS_EN to abort on plaintext outside a..z / space.
module rc4_decrypt_core #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [7:0]        s_address,
    output logic [7:0]        s_data,
    output logic              s_wren,
    input  logic [7:0]        s_q,
    output logic [MSG_AW-1:0] rom_address,
    input  logic [7:0]        rom_q,
    output logic [MSG_AW-1:0] dec_address,
    output logic [7:0]        dec_data,
    output logic              dec_wren,
    output logic [7:0]        decrypted_byte,
    output logic              busy,
    output logic              done,
    output logic              fail
);

`ifdef CHECK_CHARS_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    localparam logic [MSG_AW:0] K_LAST = (MSG_AW+1)'(MSG_LEN - 1);
    localparam logic [MSG_AW:0] K_ONE  = (MSG_AW+1)'(1);

    typedef enum logic [3:0] {
        IDLE, READ_SI, WAIT_SI, CAP_SI, READ_SJ, WAIT_SJ, CAP_SJ,
        WRITE_SI, WRITE_SJ, READ_F, WAIT_F, CAP_F, WRITE_DEC, CHECK,
        DONE, FAIL
    } state_t;

    function automatic logic is_legal(input logic [7:0] b);
        return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
    endfunction

    state_t            state_q;
    logic [7:0]        i_q, j_q, si_q, sj_q, f_q;
    logic [MSG_AW:0]   k_q;
    logic [7:0]        s_address_q, s_data_q, dec_data_q, decrypted_byte_q;
    logic [MSG_AW-1:0] rom_address_q, dec_address_q;
    logic              s_wren_q, dec_wren_q, busy_q, done_q, fail_q;
    logic [7:0]        f_d;

    assign f_d = s_q ^ rom_q;

    // Every output is registered: a state's drive becomes visible the cycle after
    // that state, which is why each RAM read is followed by a WAIT state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            i_q              <= '0;
            j_q              <= '0;
            k_q              <= '0;
            si_q             <= '0;
            sj_q             <= '0;
            f_q              <= '0;
            s_address_q      <= '0;
            s_data_q         <= '0;
            s_wren_q         <= 1'b0;
            rom_address_q    <= '0;
            dec_address_q    <= '0;
            dec_data_q       <= '0;
            dec_wren_q       <= 1'b0;
            decrypted_byte_q <= '0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            fail_q           <= 1'b0;
        end else begin
            s_wren_q   <= 1'b0;
            dec_wren_q <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q     <= '0;
                        j_q     <= '0;
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= READ_SI;
                    end
                end
                READ_SI: begin
                    i_q         <= i_q + 8'd1;
                    s_address_q <= i_q + 8'd1;
                    state_q     <= WAIT_SI;
                end
                WAIT_SI: state_q <= CAP_SI;
                CAP_SI: begin
                    si_q    <= s_q;
                    j_q     <= j_q + s_q;
                    state_q <= READ_SJ;
                end
                READ_SJ: begin
                    s_address_q <= j_q;
                    state_q     <= WAIT_SJ;
                end
                WAIT_SJ: state_q <= CAP_SJ;
                CAP_SJ: begin
                    sj_q    <= s_q;
                    state_q <= WRITE_SI;
                end
                // When i == j both writes hit one address; the later one (si) lands last.
                WRITE_SI: begin
                    s_address_q <= i_q;
                    s_data_q    <= sj_q;
                    s_wren_q    <= 1'b1;
                    state_q     <= WRITE_SJ;
                end
                WRITE_SJ: begin
                    s_address_q <= j_q;
                    s_data_q    <= si_q;
                    s_wren_q    <= 1'b1;
                    state_q     <= READ_F;
                end
                READ_F: begin
                    s_address_q   <= si_q + sj_q;
                    rom_address_q <= k_q[MSG_AW-1:0];
                    state_q       <= WAIT_F;
                end
                WAIT_F: state_q <= CAP_F;
                CAP_F: begin
                    f_q     <= f_d;
                    state_q <= WRITE_DEC;
                end
                WRITE_DEC: begin
                    dec_address_q    <= k_q[MSG_AW-1:0];
                    dec_data_q       <= f_q;
                    dec_wren_q       <= 1'b1;
                    decrypted_byte_q <= f_q;
                    state_q          <= CHECK;
                end
                CHECK: begin
                    if (CHECK_EN && !is_legal(f_q)) begin
                        fail_q  <= 1'b1;
                        state_q <= FAIL;
                    end else if (k_q == K_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q     <= k_q + K_ONE;
                        state_q <= READ_SI;
                    end
                end
                DONE, FAIL: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_address      = s_address_q;
    assign s_data         = s_data_q;
    assign s_wren         = s_wren_q;
    assign rom_address    = rom_address_q;
    assign dec_address    = dec_address_q;
    assign dec_data       = dec_data_q;
    assign dec_wren       = dec_wren_q;
    assign decrypted_byte = decrypted_byte_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign fail           = CHECK_EN & fail_q;

endmodule

// File: tb/tb_rc4_decrypt_core.sv
// Bench for rc4_decrypt_core: RAM/ROM models plus a plain-arithmetic RC4 reference.
module tb_rc4_decrypt_core;
    localparam int N  = 3;
    localparam int AW = 5;
`ifdef CHECK_CHARS_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset, start;
    logic [7:0]    s_address, s_data, s_q, rom_q, dec_data, decrypted_byte;
    logic          s_wren, dec_wren, busy, done, fail;
    logic [AW-1:0] rom_address, dec_address;

    always #5 clk = ~clk;

    rc4_decrypt_core #(.MSG_LEN(N), .MSG_AW(AW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .s_address(s_address), .s_data(s_data), .s_wren(s_wren), .s_q(s_q),
        .rom_address(rom_address), .rom_q(rom_q),
        .dec_address(dec_address), .dec_data(dec_data), .dec_wren(dec_wren),
        .decrypted_byte(decrypted_byte), .busy(busy), .done(done), .fail(fail)
    );

    logic [7:0] s_init [256];
    logic [7:0] s_mem  [256];
    logic [7:0] rom    [1<<AW];
    logic [7:0] dec_mem[1<<AW];
    int         dec_writes;
    bit         load_s, clr_dec;

    // Synchronous RAM/ROM models: read data appears one clock after the address.
    always @(posedge clk) begin
        if (load_s) begin
            for (int a = 0; a < 256; a++) s_mem[a] <= s_init[a];
        end else if (s_wren) begin
            s_mem[s_address] <= s_data;
        end
        s_q   <= s_mem[s_address];
        rom_q <= rom[rom_address];
        if (clr_dec) begin
            for (int a = 0; a < (1<<AW); a++) dec_mem[a] <= 8'h00;
            dec_writes <= 0;
        end else if (dec_wren) begin
            dec_mem[dec_address] <= dec_data;
            dec_writes <= dec_writes + 1;
        end
    end

    int errors = 0, checks = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
    endfunction

    function automatic logic [63:0] outs();
        return {17'd0, s_address, s_data, s_wren, rom_address, dec_address,
                dec_data, dec_wren, decrypted_byte, busy, done, fail};
    endfunction

    // Reference model
    logic [7:0] ks[N], exp_dec[N], exp_S[256];
    int         exp_nwr, exp_end;
    bit         exp_fail;

    task automatic ksa(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] key[3];
        logic [7:0] t;
        int j;
        key[0] = k0; key[1] = k1; key[2] = k2;
        for (int i = 0; i < 256; i++) s_init[i] = 8'(i);
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j = (j + int'(s_init[i]) + int'(key[i % 3])) % 256;
            t = s_init[i]; s_init[i] = s_init[j]; s_init[j] = t;
        end
    endtask

    task automatic prga(input bit stop);
        logic [7:0] S[256];
        logic [7:0] t;
        int i, j;
        S = s_init;
        i = 0; j = 0;
        exp_nwr = N; exp_fail = 1'b0;
        for (int k = 0; k < N; k++) begin
            i = (i + 1) % 256;
            j = (j + int'(S[i])) % 256;
            t = S[i]; S[i] = S[j]; S[j] = t;
            ks[k] = S[(int'(S[i]) + int'(S[j])) % 256];
            exp_dec[k] = ks[k] ^ rom[k];
            if (stop && CHK && !legal(exp_dec[k])) begin
                exp_nwr = k + 1; exp_fail = 1'b1;
                break;
            end
        end
        exp_S = S;
        exp_end = 13 * exp_nwr + 1;
    endtask

    task automatic prep();
        load_s = 1'b1; clr_dec = 1'b1;
        @(negedge clk);
        load_s = 1'b0; clr_dec = 1'b0;
    endtask

    int done_cyc, fail_cyc, ndone;

    // Drives one start and compares the DUT against the model every cycle until idle.
    task automatic run(input int restart_at, input int reset_at, input string tag);
        int c, widx, bad;
        widx = 0; ndone = 0; done_cyc = -1; fail_cyc = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c <= exp_end + 2) begin
            if (c == reset_at) begin
                reset = 1'b1;
                #1;
                chk({tag, " outputs_in_reset"}, outs(), 64'd0);
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            chk($sformatf("%s cyc%0d busy/done/fail", tag, c), {busy, done, fail},
                {(c <= exp_end), (c == exp_end && !exp_fail), (c == exp_end && exp_fail)});
            if (done) begin ndone++; done_cyc = c; end
            if (fail) fail_cyc = c;
            if (dec_wren) begin
                if (widx < exp_nwr) begin
                    chk($sformatf("%s dec_addr%0d", tag, widx), dec_address, widx);
                    chk($sformatf("%s dec_data%0d", tag, widx), dec_data, exp_dec[widx]);
                end else begin
                    chk({tag, " dec_write_count_live"}, widx + 1, exp_nwr);
                end
                widx++;
            end
            start = (c == restart_at);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        chk({tag, " dec_write_count"}, dec_writes, exp_nwr);
        chk({tag, " decrypted_byte"}, decrypted_byte, exp_dec[exp_nwr-1]);
        for (int k = 0; k < exp_nwr; k++)
            chk($sformatf("%s dec_mem%0d", tag, k), dec_mem[k], exp_dec[k]);
        bad = 0;
        for (int a = 0; a < 256; a++) if (s_mem[a] !== exp_S[a]) bad++;
        chk({tag, " S_final_mismatches"}, bad, 0);
    endtask

    task automatic setup_key_rom(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        ksa(8'h4B, 8'h65, 8'h79);
        rom[0] = r0; rom[1] = r1; rom[2] = r2;
        prga(1'b1);
    endtask

    initial begin
        logic [7:0] pt[N];
        int pos, r;
        reset = 1'b1; start = 1'b0; load_s = 1'b0; clr_dec = 1'b0;
        for (int a = 0; a < (1<<AW); a++) rom[a] = 8'h00;
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        repeat (2) @(negedge clk);
        chk("reset_outputs", outs(), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Known "Key" vector: keystream EB 9F 77
        setup_key_rom(8'h8A, 8'hFE, 8'h16);
        chk("model_ks0", ks[0], 8'hEB);
        chk("model_ks1", ks[1], 8'h9F);
        chk("model_ks2", ks[2], 8'h77);
        prep();
        run(0, 0, "s1");
        chk("s1_done_cycle", done_cyc, 40);
        chk("s1_dec_aaa", {dec_mem[0], dec_mem[1], dec_mem[2]}, 24'h616161);
        chk("s1_fail_never", fail_cyc, -1);

        setup_key_rom(8'hBB, 8'hF3, 8'h16);
        prep();
        run(0, 0, "s2");
`ifdef CHECK_CHARS_EN
        chk("s2_fail_cycle", fail_cyc, 14);
        chk("s2_dec0", dec_mem[0], 8'h50);
        chk("s2_no_done", ndone, 0);
`else
        chk("s2_done_cycle", done_cyc, 40);
        chk("s2_dec", {dec_mem[0], dec_mem[1], dec_mem[2]}, 24'h506C61);
`endif

        // Identity S: byte 0 has i == j == 1
        for (int a = 0; a < 256; a++) s_init[a] = 8'(a);
        rom[0] = 8'h63; rom[1] = 8'($urandom_range(255, 0)); rom[2] = 8'($urandom_range(255, 0));
        prga(1'b1);
        prep();
        run(0, 0, "ident");
        chk("ident_dec0", dec_mem[0], 8'h61);
        chk("ident_S1", s_mem[1], 8'h01);

        setup_key_rom(8'h8A, 8'hFE, 8'h16);
        prep();
        run(0, 20, "midreset");
        prep();
        run(0, 0, "after_reset");
        chk("after_reset_dec", {dec_mem[0], dec_mem[1], dec_mem[2]}, 24'h616161);
        chk("after_reset_done_cycle", done_cyc, 40);

        prep();
        run(5, 0, "restart");
        chk("restart_one_done", ndone, 1);
        chk("restart_writes", dec_writes, 3);

        for (int it = 0; it < 10; it++) begin
            ksa(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)));
            prga(1'b0);
            for (int k = 0; k < N; k++) begin
                r = $urandom_range(26, 0);
                pt[k] = (r < 26) ? 8'h61 + 8'(r) : 8'h20;
            end
            if ($urandom_range(2, 0) == 0) begin
                pos = $urandom_range(N - 1, 0);
                pt[pos] = 8'h41 + 8'($urandom_range(25, 0));
            end
            for (int k = 0; k < N; k++) rom[k] = ks[k] ^ pt[k];
            prga(1'b1);
            prep();
            run(0, 0, $sformatf("rand%0d", it));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rc4_decrypt_core.md
Name: rc4_decrypt_core

Overview:
- RC4 keystream-generation (PRGA) and XOR stage.
- Runs after the S-array init and key-schedule stages; reads and swaps the 256-byte S working RAM.
- XORs each keystream byte with the encrypted-message ROM and writes the plaintext to the decrypted-message RAM.
- Checks every plaintext byte for legality. Reports done (message valid) or fail (reject; the controller restarts key search).

Parameters:
- MSG_LEN, 32, number of message bytes processed (1..256).
- MSG_AW, 5, address width of encrypted ROM and decrypted RAM; must satisfy 2^MSG_AW >= MSG_LEN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high; clock is clk.
- start  in  1  one-cycle start pulse; sampled only in IDLE.
- s_address  out  8  S RAM address.
- s_data  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_q  in  8  S RAM read data; valid one clk after the address is presented.
- rom_address  out  MSG_AW  encrypted ROM address.
- rom_q  in  8  encrypted byte; 1-cycle read latency.
- dec_address  out  MSG_AW  decrypted RAM address.
- dec_data  out  8  plaintext byte.
- dec_wren  out  1  decrypted RAM write enable.
- decrypted_byte  out  8  last plaintext byte produced; held.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: all MSG_LEN bytes written and legal.
- fail  out  1  one-cycle pulse: illegal byte found; processing aborted.

Behaviour:
- Reset (async, any state, including mid-message):
  - State goes to IDLE.
  - i, j, k, si, sj, f and all outputs go to 0.
  - Memory contents are not restored.
- Registers: i, j, si, sj, f are 8 bit; k is MSG_AW+1 bit. All additions are mod 256 (truncate to 8 bits).
- IDLE:
  - start=1 → i=0, j=0, k=0 → READ_SI.
  - start while busy is ignored.
- Per byte k (states in order):
  - READ_SI: i←i+1; drive s_address=i+1.
  - WAIT_SI: wait one cycle for read data.
  - CAP_SI: si←s_q; j←j+s_q.
  - READ_SJ: s_address=j.
  - WAIT_SJ: wait one cycle for read data.
  - CAP_SJ: sj←s_q.
  - WRITE_SI: s_address=i, s_data=sj, s_wren=1.
  - WRITE_SJ: s_address=j, s_data=si, s_wren=1.
  - READ_F: s_address=si+sj; rom_address=k.
  - WAIT_F: wait one cycle for read data.
  - CAP_F: f←s_q XOR rom_q.
  - WRITE_DEC: dec_address=k, dec_data=f, dec_wren=1; decrypted_byte←f.
  - CHECK:
    - f illegal → FAIL.
    - else if k==MSG_LEN-1 → DONE.
    - else k←k+1 → READ_SI.
- Timing: 13 cycles per byte. From the start edge, done asserts at cycle 13*MSG_LEN+1.
- i==j boundary: WRITE_SI and WRITE_SJ hit the same address; the second write (si) wins. This matches RC4, since si==sj.
- Wrap-around: i and j wrap 255→0; the si+sj index wraps.
- DONE / FAIL: pulse done or fail for exactly one cycle → IDLE. done and fail are never asserted together.
- Write enables are high only in WRITE_SI, WRITE_SJ and WRITE_DEC. Addresses hold their last value otherwise.
- Legal byte: 0x61..0x7A (a..z) or 0x20 (space).
- On FAIL, bytes 0..k are already written to the decrypted RAM; no cleanup.

Optional Feature:
- CHECK_CHARS_EN defined:
  - CHECK applies the legality test as above.
  - fail is possible; processing aborts at the first illegal byte.
- CHECK_CHARS_EN undefined:
  - CHECK never fails; all MSG_LEN bytes are always processed, then done.
  - fail is tied to 0.
  - Cycle timing is identical in both builds.

Test Plan:
- S preloaded with the KSA result for key "Key" (0x4B,0x65,0x79); ROM[0..2]=0x8A,0xFE,0x16 (keystream 0xEB,0x9F,0x77 XOR 'a'); MSG_LEN=3; pulse start → dec RAM = 0x61,0x61,0x61; done pulse at cycle 40; fail never asserts.
- Same S; ROM[0]=0xBB (keystream XOR 'P'), CHECK_CHARS_EN defined → dec[0]=0x50; fail pulse at cycle 14; done never asserts; busy low afterwards.
- Same stimulus, CHECK_CHARS_EN undefined, MSG_LEN=3, ROM=0xBB,0xF3,0x16 → dec=0x50,0x6C,0x61; done at cycle 40.
- S set to identity (S[x]=x), MSG_LEN=1 → i=1, j=1 collision; S[1] stays 0x01; f=S[2] XOR ROM[0].
- Assert reset at cycle 20 of a run → all outputs 0 same cycle; a new start then runs from i=j=k=0 and reproduces scenario 1 results.
- Pulse start again at cycle 5 while busy → ignored; exactly one done pulse; the write count matches a single run.
